host_byte_if: RTL and testbench
===============================

Name: host_byte_if

Overview:
- Upstream feeder for the internal 16-bit data bus mux (master port 1).
- Accepts byte writes from an external asynchronous 8-bit host bus and synchronises the strobes into clk.
- Assembles byte pairs into 16-bit words.
- Presents each completed word as int_data plus a one-cycle state qualifier: command word or data word.
- No downstream backpressure exists: the consumer latches on any nonzero state.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the host_wr_n / host_rs synchroniser; legal values 2..4.
- TIMEOUT, 1024, clk cycles a half-assembled word may wait for its high byte before it is discarded; legal values 2..65535.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- host_d  in  8  host data byte; must be stable while host_wr_n is low.
- host_wr_n  in  1  host write strobe, active low, asynchronous to clk; minimum low time is SYNC_STAGES+2 clk cycles.
- host_rs  in  1  register select, stable with host_d: 0 = command byte, 1 = data byte.
- host_busy  out  1  high while a word is being emitted or a byte is being captured; host may ignore it if its timing is respected.
- int_data  out  16  assembled word, {high byte, low byte}.
- state  out  2  word qualifier, one-cycle pulse: 00 idle, 01 command word, 10 data word; 11 is never driven.
- err_timeout  out  1  one-cycle pulse when a pending low byte is discarded by timeout.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - resetn is asynchronous and active-low.
  - On reset, all outputs are 0 (int_data=0, state=00, host_busy=0, err_timeout=0).
  - Synchroniser flops reset to 1 (strobe inactive), pointer to LOW, timeout counter to 0.
- Strobe detection:
  - host_wr_n passes through SYNC_STAGES flops. A falling edge is detected on the last two stages.
  - On the detect cycle, host_d and the synchronised host_rs are sampled into byte registers.
  - host_d is sampled directly. Host timing guarantees it is stable by then.
  - Further falling edges are detected only after host_wr_n returns high, so one strobe produces one capture.
- FSM states:
  - IDLE: waits for a strobe.
    - On capture: store low byte and rs, go to HAVE_LOW, clear counter.
  - HAVE_LOW: counter increments each cycle.
    - On capture with the same rs: form word {new byte, low byte}, go to EMIT.
    - On capture with a different rs: discard the old low byte, store the new byte as low byte with its rs, stay in HAVE_LOW, clear counter. No err pulse.
    - Counter reaches TIMEOUT-1 with no capture: discard the low byte, pulse err_timeout for one cycle, go to IDLE.
    - Capture and timeout in the same cycle: the capture wins (treated as an in-time high byte).
  - EMIT: lasts exactly one cycle. Drives state=01 (rs=0) or 10 (rs=1) and go to IDLE.
    - int_data is updated on the EMIT cycle and holds its value afterwards until the next EMIT.
    - A strobe detected in the EMIT cycle is captured as a new low byte: go to HAVE_LOW instead of IDLE.
- Output timing:
  - state is registered and nonzero exactly one cycle per word.
  - Latency: the rising edge of the high-byte detect cycle is followed by the state pulse on the next clk.
- host_busy is high in HAVE_LOW and EMIT, otherwise low.
- Reset mid-operation: any pending low byte is lost, no word is emitted, and no err pulse is generated.

Test Plan:
- Reset then idle 50 cycles: int_data=0000, state=00, host_busy=0, err_timeout=0 throughout.
- Write rs=1 bytes 0x34 then 0x12 (each strobe low 6 cycles, 10 cycles apart): exactly one cycle of state=10 with int_data=1234, then state=00 with int_data held at 1234.
- Write rs=0 byte 0xAA, then rs=1 bytes 0xCD, 0xAB: 0xAA is discarded silently; one pulse state=10, int_data=ABCD; no state=01 and no err pulse.
- Write rs=0 byte 0x55, then nothing for 1100 cycles (TIMEOUT=1024): err_timeout pulses once 1024 cycles after capture; host_busy drops; the next pair 0x01,0x02 with rs=0 gives state=01, int_data=0201.
- Write low byte 0x77 (rs=1), assert resetn low for 3 cycles asynchronously mid-HAVE_LOW, then write 0x11, 0x22: no word from 0x77; the single output is state=10, int_data=2211.
- Strobe glitch test: hold host_wr_n low 40 cycles for one byte: exactly one capture; two full strobes yield exactly one word.

Source files
------------

// File: rtl/host_byte_if.sv
// Host byte interface: synchronises an asynchronous 8-bit host write strobe and
// packs byte pairs into 16-bit command/data words for the internal bus mux.
module host_byte_if #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  host_d,
    input  logic        host_wr_n,
    input  logic        host_rs,
    output logic        host_busy,
    output logic [15:0] int_data,
    output logic [1:0]  state,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HAVE_LOW = 2'd1,
        S_EMIT     = 2'd2
    } fsm_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] wr_sync_q;
    logic [SYNC_STAGES-1:0] rs_sync_q;
    logic                   capture;
    logic                   cap_rs;

    fsm_t        fsm_q;
    logic [7:0]  lo_byte_q;
    logic        lo_rs_q;
    logic [15:0] cnt_q;
    logic [15:0] data_q;
    logic [1:0]  word_state_q;
    logic        busy_q;
    logic        err_q;

    // Both chains reset to 1 so leaving reset never looks like a strobe edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_sync_q <= '1;
            rs_sync_q <= '1;
        end else begin
            wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], host_wr_n};
            rs_sync_q <= {rs_sync_q[SYNC_STAGES-2:0], host_rs};
        end
    end

    // Falling edge seen between the last two wr stages; rs is taken from the
    // last stage, so it must be set up at least one clk before the strobe falls.
    assign capture = wr_sync_q[SYNC_STAGES-1] & ~wr_sync_q[SYNC_STAGES-2];
    assign cap_rs  = rs_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fsm_q        <= S_IDLE;
            lo_byte_q    <= 8'h00;
            lo_rs_q      <= 1'b0;
            cnt_q        <= 16'd0;
            data_q       <= 16'h0000;
            word_state_q <= 2'b00;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            word_state_q <= 2'b00;
            err_q        <= 1'b0;
            case (fsm_q)
                S_IDLE, S_EMIT: begin
                    if (capture) begin
                        lo_byte_q <= host_d;
                        lo_rs_q   <= cap_rs;
                        cnt_q     <= 16'd0;
                        fsm_q     <= S_HAVE_LOW;
                        busy_q    <= 1'b1;
                    end else begin
                        fsm_q     <= S_IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                S_HAVE_LOW: begin
                    // A capture outranks a timeout landing on the same cycle.
                    if (capture) begin
                        if (cap_rs == lo_rs_q) begin
                            data_q       <= {host_d, lo_byte_q};
                            word_state_q <= cap_rs ? 2'b10 : 2'b01;
                            fsm_q        <= S_EMIT;
                        end else begin
                            lo_byte_q    <= host_d;
                            lo_rs_q      <= cap_rs;
                            cnt_q        <= 16'd0;
                        end
                        busy_q <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        fsm_q  <= S_IDLE;
                        busy_q <= 1'b0;
                        err_q  <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    fsm_q  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign host_busy   = busy_q;
    assign int_data    = data_q;
    assign state       = word_state_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_host_byte_if.sv
// Self-checking bench for host_byte_if: directed scenarios plus randomized host
// writes compared against a byte-pairing reference model.
module tb_host_byte_if;

    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 1024;

    logic        clk       = 1'b0;
    logic        resetn    = 1'b0;
    logic [7:0]  host_d    = 8'h00;
    logic        host_wr_n = 1'b1;
    logic        host_rs   = 1'b0;
    logic        host_busy;
    logic [15:0] int_data;
    logic [1:0]  state;
    logic        err_timeout;

    host_byte_if #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .host_d      (host_d),
        .host_wr_n   (host_wr_n),
        .host_rs     (host_rs),
        .host_busy   (host_busy),
        .int_data    (int_data),
        .state       (state),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed words and error pulses, sampled mid-cycle.
    logic [17:0] got_q[$];
    int          got_cyc[$];
    int          err_cnt   = 0;
    int          err_cyc   = -1;
    int          bad_state = 0;

    always @(negedge clk) begin
        if (resetn) begin
            if (state != 2'b00) begin
                got_q.push_back({state, int_data});
                got_cyc.push_back(cyc);
                $display("word: cyc=%0d state=%b int_data=%h", cyc, state, int_data);
            end
            if (state == 2'b11) bad_state <= bad_state + 1;
            if (err_timeout) begin
                err_cnt <= err_cnt + 1;
                err_cyc <= cyc;
                $display("timeout pulse: cyc=%0d", cyc);
            end
        end
    end

    // Reference model: pairs bytes of equal rs, a mismatching rs restarts the pair.
    bit          m_pend = 1'b0;
    logic [7:0]  m_lo   = 8'h00;
    bit          m_rs   = 1'b0;
    logic [17:0] exp_q[$];

    function automatic void model_write(bit rs, logic [7:0] d);
        if (m_pend && m_rs == rs) begin
            exp_q.push_back({(rs ? 2'b10 : 2'b01), d, m_lo});
            m_pend = 1'b0;
        end else begin
            m_pend = 1'b1;
            m_lo   = d;
            m_rs   = rs;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        err_cnt = 0;
        err_cyc = -1;
    endtask

    task automatic host_write(input bit rs, input logic [7:0] d, input int low_cyc,
                              input int gap_cyc, output int fall_cyc);
        @(negedge clk);
        host_rs = rs;
        host_d  = d;
        tick(2);
        fall_cyc  = cyc;
        host_wr_n = 1'b0;
        tick(low_cyc);
        host_wr_n = 1'b1;
        tick(gap_cyc);
        model_write(rs, d);
        $display("host write: rs=%0d d=%h low=%0d fall_cyc=%0d", rs, d, low_cyc, fall_cyc);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetn = 1'b0;
        tick(3);
        resetn = 1'b1;
        m_pend = 1'b0;
        tick(2);
        clear_obs();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(3);
        n_cmp++;
        if ({int_data, state, host_busy, err_timeout} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got data=%h state=%b busy=%b err=%b want 0", int_data, state, host_busy, err_timeout);
        end
        resetn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            n_cmp++;
            if ({int_data, state, host_busy, err_timeout} !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got data=%h state=%b busy=%b err=%b want 0", i, int_data, state, host_busy, err_timeout);
            end
        end
        clear_obs();
    endtask

    task automatic test_data_pair();
        int f1, f2;
        clear_obs();
        host_write(1'b1, 8'h34, 6, 10, f1);
        host_write(1'b1, 8'h12, 6, 10, f2);
        n_cmp++;
        if (got_q.size() !== 1 || got_q[0] !== {2'b10, 16'h1234}) begin
            n_fail++;
            $display("FAIL pair_word: got %0d words first=%h want 1 word %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 18'h0, {2'b10, 16'h1234});
        end
        n_cmp++;
        if (got_cyc.size() !== 1 || got_cyc[0] - f2 !== SYNC_STAGES) begin
            n_fail++;
            $display("FAIL pair_latency: got %0d cycles want %0d", (got_cyc.size() > 0) ? got_cyc[0] - f2 : -1, SYNC_STAGES);
        end
        n_cmp++;
        if (state !== 2'b00 || int_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL pair_hold: got state=%b data=%h want 00 1234", state, int_data);
        end
    endtask

    task automatic test_rs_switch();
        int f;
        clear_obs();
        host_write(1'b0, 8'hAA, 6, 10, f);
        host_write(1'b1, 8'hCD, 6, 10, f);
        host_write(1'b1, 8'hAB, 6, 10, f);
        n_cmp++;
        if (got_q.size() !== 1 || got_q[0] !== {2'b10, 16'hABCD}) begin
            n_fail++;
            $display("FAIL rs_switch_word: got %0d words first=%h want 1 word %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 18'h0, {2'b10, 16'hABCD});
        end
        n_cmp++;
        if (err_cnt !== 0) begin
            n_fail++;
            $display("FAIL rs_switch_err: got %0d err pulses want 0", err_cnt);
        end
    endtask

    task automatic test_timeout();
        int f;
        clear_obs();
        host_write(1'b0, 8'h55, 6, 0, f);
        for (int i = 0; i < 1100; i++) begin
            tick(1);
            if (i == 500) begin
                n_cmp++;
                if (host_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout_busy_wait: got busy=%b want 1", host_busy);
                end
            end
        end
        m_pend = 1'b0;
        n_cmp++;
        if (err_cnt !== 1) begin
            n_fail++;
            $display("FAIL timeout_count: got %0d err pulses want 1", err_cnt);
        end
        n_cmp++;
        if (err_cyc - f !== SYNC_STAGES + TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_delay: got %0d cycles after strobe want %0d", err_cyc - f, SYNC_STAGES + TIMEOUT);
        end
        n_cmp++;
        if (host_busy !== 1'b0 || got_q.size() !== 0) begin
            n_fail++;
            $display("FAIL timeout_after: got busy=%b words=%0d want 0 0", host_busy, got_q.size());
        end
        host_write(1'b0, 8'h01, 6, 10, f);
        host_write(1'b0, 8'h02, 6, 10, f);
        n_cmp++;
        if (got_q.size() !== 1 || got_q[0] !== {2'b01, 16'h0201}) begin
            n_fail++;
            $display("FAIL timeout_next_word: got %0d words first=%h want 1 word %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 18'h0, {2'b01, 16'h0201});
        end
    endtask

    task automatic test_reset_mid();
        int f;
        clear_obs();
        host_write(1'b1, 8'h77, 6, 10, f);
        n_cmp++;
        if (host_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_busy_before: got busy=%b want 1", host_busy);
        end
        #3 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({int_data, state, host_busy, err_timeout} !== 20'h0) begin
            n_fail++;
            $display("FAIL midreset_async: got data=%h state=%b busy=%b err=%b want 0", int_data, state, host_busy, err_timeout);
        end
        tick(3);
        resetn = 1'b1;
        m_pend = 1'b0;
        host_write(1'b1, 8'h11, 6, 10, f);
        host_write(1'b1, 8'h22, 6, 10, f);
        n_cmp++;
        if (got_q.size() !== 1 || got_q[0] !== {2'b10, 16'h2211} || err_cnt !== 0) begin
            n_fail++;
            $display("FAIL midreset_word: got %0d words first=%h errs=%0d want 1 word %h 0 errs", got_q.size(), (got_q.size() > 0) ? got_q[0] : 18'h0, err_cnt, {2'b10, 16'h2211});
        end
    endtask

    task automatic test_long_strobe();
        int f;
        clear_obs();
        host_write(1'b0, 8'h3C, 40, 10, f);
        n_cmp++;
        if (got_q.size() !== 0 || host_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL long_strobe_single: got words=%0d busy=%b want 0 1", got_q.size(), host_busy);
        end
        host_write(1'b0, 8'h5A, 40, 10, f);
        n_cmp++;
        if (got_q.size() !== 1 || got_q[0] !== {2'b01, 16'h5A3C}) begin
            n_fail++;
            $display("FAIL long_strobe_word: got %0d words first=%h want 1 word %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 18'h0, {2'b01, 16'h5A3C});
        end
    endtask

    task automatic test_back_to_back();
        int f;
        clear_obs();
        for (int i = 0; i < 40; i++) begin
            host_write(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                       $urandom_range(SYNC_STAGES + 2, SYNC_STAGES + 6),
                       $urandom_range(SYNC_STAGES + 1, 10), f);
        end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d words want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (err_cnt !== 0 || bad_state !== 0) begin
            n_fail++;
            $display("FAIL b2b_err_state: got errs=%0d state11=%0d want 0 0", err_cnt, bad_state);
        end
        pulse_reset();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_data_pair();
        test_rs_switch();
        test_timeout();
        test_reset_mid();
        test_long_strobe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
